regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core, replacing the fixed 2R/1W file.
- Adds write-to-read bypass, asynchronous reset clearing of every register, and a per-register busy scoreboard (set at issue, cleared at writeback). Decode uses the scoreboard for hazard stalls.
- Sits between decode (read/issue) and writeback (write ports).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >=2).
- AW, $clog2(NREG), register address width (derived; not overridden).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; higher index has priority on the same address.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never marked busy.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ra  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- rd  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rbusy  out  NRD  scoreboard busy bit of the register addressed by ra port i.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- iss_valid  in  1  issue strobe: mark iss_rd busy.
- iss_rd  in  AW  destination register of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_vec  out  NREG  full scoreboard, for debug and the hazard unit.

Behaviour:
- Reset (rst=1, asynchronous): all NREG registers <= 0 and all busy bits <= 0, immediately. While rst is high, rd=0, rbusy=0, busy_vec=0. Writes and issues are ignored. Deassertion takes effect at the next rising clk.
- Storage write: on posedge clk, for each port j with we[j]=1, reg[wa_j] <= wd_j. If two ports target the same address, the highest j wins.
- ZERO_REG=1: writes to address 0 are dropped.
- Read (combinational, 0-cycle latency):
  - If ZERO_REG=1 and ra_i=0, rd_i=0.
  - Otherwise, if any we[j]=1 with wa_j==ra_i (and wa_j is not the zero register), rd_i = wd of the highest such j. This is write-first bypass.
  - Otherwise rd_i = reg[ra_i].
- No X-propagation: every register has a defined reset value, so no X-scrubbing logic is present.
- Scoreboard (busy[NREG]), next-state per register r, evaluated in priority order:
  - flush=1 -> 0, overrides everything including issue in the same cycle.
  - iss_valid=1 and iss_rd==r (and r is not the zero register) -> 1. Set beats clear, because it is a new producer.
  - any we[j]=1 with wa_j==r -> 0.
  - otherwise hold.
- rbusy_i = busy[ra_i] & ~(writeback clearing ra_i this cycle). A register being written this cycle reads as not busy with the bypassed data, so there is no extra stall. Forced 0 for the zero register when ZERO_REG=1.
- No ready/valid handshake. The caller must not issue to a register that is already busy.
- A write to a non-busy register is legal: storage updates and busy stays 0.
- Reset mid-operation: pending busy bits and in-flight writes are discarded. Contents return to 0.
- Width rules: addresses compare at full AW. NREG must equal 2**AW; any other value is an elaboration error via a generate-time check.

Decomposition:
- Shared package rv_core_pkg:
  - XLEN_DEF=32 and NREG_DEF=32.
  - Typedefs xword_t and regaddr_t.
  - Constant REG_ZERO=0.
- One natural sub-module: regfile_scoreboard, holding the busy vector with its set/clear/flush priority logic.
- The storage array and bypass muxes stay in regfile_mp_sb.

Test Plan:
- Reset and zero register:
  - Assert rst mid-run after writing x5=0xDEADBEEF -> rd for x5 reads 0 immediately (asynchronous).
  - Write 0x1234 to x0 -> rd(x0)=0 and busy[0]=0.
- Write/read and bypass:
  - Cycle N: we[0]=1, wa0=7, wd0=0xA5A5A5A5, ra0=7 -> rd0=0xA5A5A5A5 in the same cycle.
  - Cycle N+1, no write -> rd0=0xA5A5A5A5 from storage.
- Dual-write conflict: we=2'b11, wa0=wa1=3, wd0=0x11, wd1=0x22 -> same-cycle rd(x3)=0x22 and stored x3=0x22.
- Scoreboard lifecycle:
  - iss_valid with iss_rd=9 -> busy_vec[9]=1 next cycle; ra1=9 gives rbusy1=1.
  - Writeback we[1]=1, wa1=9 -> rbusy1=0 in the same cycle, rd1=wd1, busy_vec[9]=0 next cycle.
- Simultaneous events:
  - iss_rd=4 together with a write to x4 -> busy[4]=1 (set wins).
  - flush together with iss_rd=6 -> busy_vec=0.
- Parameter sweep: NREG=16, NRD=3, NWR=1, ZERO_REG=0 -> x0 is writable; random write/read traffic matches a reference model over 10k cycles.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core types and constants for the integer register file
// and its users in decode and writeback.
package rv_core_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

  typedef logic [XLEN_DEF-1:0]         xword_t;
  typedef logic [$clog2(NREG_DEF)-1:0] regaddr_t;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback side bundle of the multi-port register file.
// master = pipeline, slave = register file.
interface regfile_mp_sb_if
  import rv_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output ra, we, wa, wd,
    output iss_valid, iss_rd, flush,
    input  rd, rbusy, busy_vec
  );

  modport slave (
    input  ra, we, wa, wd,
    input  iss_valid, iss_rd, flush,
    output rd, rbusy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback,
// wiped by a pipeline flush.
module regfile_scoreboard
  import rv_core_pkg::*;
#(
  parameter  int NREG     = NREG_DEF,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  output logic [NREG-1:0]   busy_vec
);
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            iss_zero;

  assign iss_zero = (ZERO_REG != 0) && (iss_rd == AW'(REG_ZERO));

  // Applied lowest to highest priority: clear, set, flush.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_d[wa[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid && !iss_zero) busy_d[iss_rd] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-first bypass
// and an issue/writeback busy scoreboard.
module regfile_mp_sb
  import rv_core_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREG     = NREG_DEF,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input logic            clk,
  input logic            rst,
  regfile_mp_sb_if.slave bus
);
  if (NREG < 2 || NREG != (1 << AW)) begin : g_bad_nreg
    $error("regfile_mp_sb: NREG must be a power of two >= 2");
  end

  function automatic logic is_zero(logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(REG_ZERO));
  endfunction

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy;

  // Ascending port order lets the highest write port win.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWR; j++) begin
      if (bus.we[j] && !is_zero(bus.wa[j*AW +: AW]))
        mem_d[bus.wa[j*AW +: AW]] = bus.wd[j*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .we        (bus.we),
    .wa        (bus.wa),
    .busy_vec  (busy)
  );

  assign bus.busy_vec = busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] byp;

    assign a = bus.ra[i*AW +: AW];

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.wa[j*AW +: AW] == a) begin
          hit = 1'b1;
          byp = bus.wd[j*XLEN +: XLEN];
        end
      end
    end

    assign bus.rd[i*XLEN +: XLEN] =
      (rst || is_zero(a)) ? '0 : (hit ? byp : mem_q[a]);

    // A register written back this cycle is already resolved.
    assign bus.rbusy[i] = !rst && !is_zero(a) && !hit && busy[a];
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised bench for regfile_mp_sb against an array-based model,
// in the default shape and in a 16x3R/1W no-zero-register shape.
module tb_regfile_mp_sb;
  import rv_core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) ifa ();
  regfile_mp_sb_if #(.XLEN(32), .NREG(16), .NRD(3), .NWR(1)) ifb ();

  regfile_mp_sb #(
    .XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

  regfile_mp_sb #(
    .XLEN(32), .NREG(16), .NRD(3), .NWR(1), .ZERO_REG(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  // ---------------- model A: 32 regs, 2R/2W, x0 hardwired
  xword_t     ma_reg [32];
  bit         ma_busy[32];
  logic [1:0] a_we;
  logic [4:0] a_wa [2];
  xword_t     a_wd [2];
  logic [4:0] a_ra [2];
  logic       a_iss;
  logic [4:0] a_iss_rd;
  logic       a_flush;

  function automatic xword_t a_exp_rd(logic [4:0] r);
    if (r == 0) return '0;
    if (a_we[1] && a_wa[1] == r) return a_wd[1];
    if (a_we[0] && a_wa[0] == r) return a_wd[0];
    return ma_reg[r];
  endfunction

  function automatic logic a_exp_rbusy(logic [4:0] r);
    if (r == 0) return 1'b0;
    for (int j = 0; j < 2; j++)
      if (a_we[j] && a_wa[j] == r) return 1'b0;
    return ma_busy[r];
  endfunction

  function automatic logic [31:0] a_exp_bv();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = ma_busy[r];
    return v;
  endfunction

  task automatic a_idle();
    a_we = '0; a_iss = 1'b0; a_iss_rd = '0; a_flush = 1'b0;
    for (int j = 0; j < 2; j++) begin a_wa[j] = '0; a_wd[j] = '0; a_ra[j] = '0; end
  endtask

  task automatic a_apply();
    ifa.we = a_we;
    ifa.wa = {a_wa[1], a_wa[0]};
    ifa.wd = {a_wd[1], a_wd[0]};
    ifa.ra = {a_ra[1], a_ra[0]};
    ifa.iss_valid = a_iss;
    ifa.iss_rd = a_iss_rd;
    ifa.flush = a_flush;
  endtask

  task automatic a_check();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rd%0d", i), 64'(ifa.rd[i*32 +: 32]), 64'(a_exp_rd(a_ra[i])));
      check($sformatf("rbusy%0d", i), 64'(ifa.rbusy[i]), 64'(a_exp_rbusy(a_ra[i])));
    end
    check("busy_vec", 64'(ifa.busy_vec), 64'(a_exp_bv()));
  endtask

  task automatic a_update();
    for (int j = 0; j < 2; j++)
      if (a_we[j] && a_wa[j] != 0) ma_reg[a_wa[j]] = a_wd[j];
    if (a_flush) begin
      for (int r = 0; r < 32; r++) ma_busy[r] = 1'b0;
    end else begin
      for (int j = 0; j < 2; j++) if (a_we[j]) ma_busy[a_wa[j]] = 1'b0;
      if (a_iss && a_iss_rd != 0) ma_busy[a_iss_rd] = 1'b1;
    end
  endtask

  task automatic a_tick();
    a_apply();
    #1 a_check();
    @(posedge clk);
    a_update();
    @(negedge clk);
  endtask

  // ---------------- model B: 16 regs, 3R/1W, x0 ordinary
  xword_t     mb_reg [16];
  bit         mb_busy[16];
  logic       b_we;
  logic [3:0] b_wa;
  xword_t     b_wd;
  logic [3:0] b_ra [3];
  logic       b_iss;
  logic [3:0] b_iss_rd;
  logic       b_flush;

  task automatic b_idle();
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_iss = 1'b0; b_iss_rd = '0; b_flush = 1'b0;
    for (int i = 0; i < 3; i++) b_ra[i] = '0;
  endtask

  task automatic b_apply();
    ifb.we = b_we;
    ifb.wa = b_wa;
    ifb.wd = b_wd;
    ifb.ra = {b_ra[2], b_ra[1], b_ra[0]};
    ifb.iss_valid = b_iss;
    ifb.iss_rd = b_iss_rd;
    ifb.flush = b_flush;
  endtask

  task automatic b_tick();
    logic [15:0] bv;
    b_apply();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b_rd%0d", i), 64'(ifb.rd[i*32 +: 32]),
            64'((b_we && b_wa == b_ra[i]) ? b_wd : mb_reg[b_ra[i]]));
      check($sformatf("b_rbusy%0d", i), 64'(ifb.rbusy[i]),
            64'((b_we && b_wa == b_ra[i]) ? 1'b0 : mb_busy[b_ra[i]]));
    end
    for (int r = 0; r < 16; r++) bv[r] = mb_busy[r];
    check("b_busy_vec", 64'(ifb.busy_vec), 64'(bv));
    @(posedge clk);
    if (b_we) mb_reg[b_wa] = b_wd;
    if (b_flush) begin
      for (int r = 0; r < 16; r++) mb_busy[r] = 1'b0;
    end else begin
      if (b_we) mb_busy[b_wa] = 1'b0;
      if (b_iss) mb_busy[b_iss_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic models_reset();
    for (int r = 0; r < 32; r++) begin ma_reg[r] = '0; ma_busy[r] = 1'b0; end
    for (int r = 0; r < 16; r++) begin mb_reg[r] = '0; mb_busy[r] = 1'b0; end
  endtask

  initial begin
    rst = 1'b1;
    a_idle(); b_idle(); a_apply(); b_apply();
    models_reset();
    repeat (2) @(negedge clk);
    phase = "reset";
    #1 a_check();
    check("b_busy_rst", 64'(ifb.busy_vec), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    phase = "wr_x5";
    a_idle(); a_we = 2'b01; a_wa[0] = 5; a_wd[0] = 32'hDEADBEEF; a_ra[0] = 5;
    a_tick();
    a_idle(); a_ra[0] = 5; a_iss = 1'b1; a_iss_rd = 8; a_ra[1] = 8;
    a_tick();

    phase = "async_rst";
    a_idle(); a_ra[0] = 5; a_ra[1] = 8; a_apply();
    #1 check("x5_before", 64'(ifa.rd[31:0]), 64'h0DEADBEEF);
    check("x8_busy_before", 64'(ifa.busy_vec[8]), 64'd1);
    rst = 1'b1;
    #1 check("x5_in_rst", 64'(ifa.rd[31:0]), 64'd0);
    check("bv_in_rst", 64'(ifa.busy_vec), 64'd0);
    models_reset();
    @(negedge clk);
    rst = 1'b0;
    a_tick();

    phase = "x0";
    a_idle(); a_we = 2'b01; a_wa[0] = 0; a_wd[0] = 32'h1234; a_ra[0] = 0;
    a_iss = 1'b1; a_iss_rd = 0;
    a_tick();
    a_idle(); a_ra[1] = 0;
    a_tick();

    phase = "bypass";
    a_idle(); a_we = 2'b01; a_wa[0] = 7; a_wd[0] = 32'hA5A5A5A5; a_ra[0] = 7;
    a_tick();
    a_idle(); a_ra[0] = 7;
    a_tick();

    phase = "dual_wr";
    a_idle(); a_we = 2'b11; a_wa[0] = 3; a_wa[1] = 3;
    a_wd[0] = 32'h11; a_wd[1] = 32'h22; a_ra[0] = 3;
    a_tick();
    a_idle(); a_ra[1] = 3;
    a_tick();

    phase = "sb_life";
    a_idle(); a_iss = 1'b1; a_iss_rd = 9;
    a_tick();
    a_idle(); a_ra[1] = 9;
    a_tick();
    a_idle(); a_we = 2'b10; a_wa[1] = 9; a_wd[1] = 32'hCAFE0009; a_ra[1] = 9;
    a_tick();
    a_idle(); a_ra[1] = 9;
    a_tick();

    phase = "set_wins";
    a_idle(); a_iss = 1'b1; a_iss_rd = 4; a_we = 2'b01; a_wa[0] = 4;
    a_wd[0] = 32'h44; a_ra[0] = 4;
    a_tick();
    a_idle(); a_ra[0] = 4;
    a_tick();

    phase = "flush";
    a_idle(); a_flush = 1'b1; a_iss = 1'b1; a_iss_rd = 6; a_ra[0] = 6;
    a_tick();
    a_idle(); a_ra[0] = 6;
    a_tick();

    phase = "rand_a";
    for (int n = 0; n < 2000; n++) begin
      a_idle();
      a_we = 2'($urandom);
      for (int j = 0; j < 2; j++) begin
        a_wa[j] = 5'($urandom);
        a_wd[j] = $urandom;
        a_ra[j] = ($urandom_range(0, 3) == 0) ? a_wa[j] : 5'($urandom);
      end
      a_iss_rd = 5'($urandom);
      a_iss = ($urandom_range(0, 3) == 0) && !ma_busy[a_iss_rd];
      a_flush = ($urandom_range(0, 31) == 0);
      a_tick();
    end
    a_idle(); a_apply();

    phase = "b_x0";
    b_idle(); b_we = 1'b1; b_wa = 0; b_wd = 32'h1234; b_ra[0] = 0;
    b_iss = 1'b1; b_iss_rd = 0;
    b_tick();
    b_idle(); b_ra[1] = 0;
    b_tick();

    phase = "rand_b";
    for (int n = 0; n < 10000; n++) begin
      b_idle();
      b_we = 1'($urandom);
      b_wa = 4'($urandom);
      b_wd = $urandom;
      for (int i = 0; i < 3; i++)
        b_ra[i] = ($urandom_range(0, 3) == 0) ? b_wa : 4'($urandom);
      b_iss_rd = 4'($urandom);
      b_iss = ($urandom_range(0, 3) == 0) && !mb_busy[b_iss_rd];
      b_flush = ($urandom_range(0, 63) == 0);
      b_tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
